// File: rtl/exposure_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exposure_seq_pkg
// Description : Shared types and default widths for the exposure sequencer.
//               It holds the frame state encoding, the default counter widths
//               and a small width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package exposure_seq_pkg;

  // Default exposure counter width and frame count width
  localparam int C_EXP_W = 24;
  localparam int C_FRM_W = 16;

  // Frame sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRST   = 3'd1,
    ST_EXPOSE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_REQ    = 3'd4,
    ST_READ   = 3'd5,
    ST_ACK    = 3'd6
  } seq_state_e;

  // Larger of two integers; used to size the shared phase timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_timer
// Description : Loadable down-counter with an enable and a zero flag. It is
//               shared by the global-reset, exposure and settle phases. Load
//               has priority, and the counter holds once it reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  // Count down from the loaded value and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/exposure_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exposure_sequencer
// Description : Frame-level exposure/readout controller on ADC_PIXCLK.
//               Each frame runs global pixel reset, then the DRAIN_B exposure
//               window and a settle gap. The module then issues a readout
//               request over the FSMIND0/FSMIND1 handshake and acknowledges
//               completion. It supports single, N-frame and continuous runs.
//               Optional macro READOUT_TIMEOUT_EN adds a readout watchdog
//               that drives a sticky ERROR flag.
// Revision    : 1.0 - initial release
// ============================================================================
module exposure_sequencer #(
  parameter int C_EXP_W      = exposure_seq_pkg::C_EXP_W,
  parameter int C_FRM_W      = exposure_seq_pkg::C_FRM_W,
  parameter int C_GRST_CNT   = 16,
  parameter int C_SETTLE_CNT = 4,
  parameter int C_TIMEOUT    = 65535
) (
  input  logic               ADC_PIXCLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               ABORT,
  input  logic               CONTINUOUS,
  input  logic [C_FRM_W-1:0] NUM_FRAMES,
  input  logic [C_EXP_W-1:0] EXP_TIME,
  input  logic               FSMIND0,
  input  logic               FSMIND1ACK,
  output logic               FSMIND1,
  output logic               FSMIND0ACK,
  output logic               PIXRES_G,
  output logic               DRAIN_B,
  output logic               BUSY,
  output logic               FRAME_DONE,
  output logic [C_FRM_W-1:0] FRAME_CNT,
  output logic               ERROR
);

  import exposure_seq_pkg::*;

  // The timer must hold the longest phase minus one
  localparam int c_tmr_w = max_int(max_int(C_EXP_W, $clog2(C_GRST_CNT + 1)),
                                   $clog2(C_SETTLE_CNT + 1));
  localparam logic [c_tmr_w-1:0] c_grst_ld   = c_tmr_w'(C_GRST_CNT - 1);
  localparam logic [c_tmr_w-1:0] c_settle_ld = c_tmr_w'(C_SETTLE_CNT - 1);

  seq_state_e         r_state;
  logic [C_EXP_W-1:0] r_exp_m1;
  logic [C_FRM_W-1:0] r_num_frames;
  logic [C_FRM_W-1:0] r_frame_cnt;
  logic               r_abort_pend;
  logic               r_fsmind1;
  logic               r_fsmind0ack;
  logic               r_pixres;
  logic               r_drain;
  logic               r_busy;
  logic               r_frame_done;

  logic               w_tmr_load;
  logic [c_tmr_w-1:0] w_tmr_val;
  logic               w_tmr_en;
  logic               w_tmr_zero;
  logic               w_timeout;
  logic               w_ack_to_idle;
  logic               w_start_ok;

  assign w_start_ok = START && !ABORT;

  // Leaving ACK: stop on pending or live abort, or when the last frame is done.
  // r_frame_cnt already includes the frame being acknowledged.
  assign w_ack_to_idle = r_abort_pend || ABORT ||
                         (!CONTINUOUS && (r_frame_cnt == r_num_frames));

  seq_timer #(
    .W (c_tmr_w)
  ) u_timer (
    .clk      (ADC_PIXCLK),
    .rst_n    (RESET_N),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .en       (w_tmr_en),
    .zero     (w_tmr_zero)
  );

  // Load the timer with (length-1) on entry to each timed phase, then count down
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_tmr_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = c_grst_ld;
        end
      end
      ST_GRST: begin
        if (!ABORT) begin
          if (w_tmr_zero) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = c_tmr_w'(r_exp_m1);
          end else begin
            w_tmr_en = 1'b1;
          end
        end
      end
      ST_EXPOSE: begin
        if (!ABORT) begin
          if (w_tmr_zero) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = c_settle_ld;
          end else begin
            w_tmr_en = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        w_tmr_en = !ABORT;
      end
      ST_ACK: begin
        if (!w_ack_to_idle) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = c_grst_ld;
        end
      end
      default: begin
      end
    endcase
  end

`ifdef READOUT_TIMEOUT_EN
  localparam int c_wd_w = $clog2(C_TIMEOUT + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(C_TIMEOUT - 1);

  logic [c_wd_w-1:0] r_wdog;
  logic              r_error;

  // Count the cycles spent waiting on the readout side (REQ and READ)
  always_ff @(posedge ADC_PIXCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wdog <= '0;
    end else if ((r_state == ST_REQ) || (r_state == ST_READ)) begin
      r_wdog <= r_wdog + 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

  assign w_timeout = ((r_state == ST_REQ) || (r_state == ST_READ)) &&
                     (r_wdog == c_wd_last);

  // Sticky error: set on watchdog expiry, cleared by an accepted start
  always_ff @(posedge ADC_PIXCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_error <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_start_ok) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end
  end

  assign ERROR = r_error;
`else
  assign w_timeout = 1'b0;
  assign ERROR     = 1'b0;
`endif

  // Frame sequencing FSM with registered outputs
  always_ff @(posedge ADC_PIXCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= ST_IDLE;
      r_exp_m1     <= '0;
      r_num_frames <= '0;
      r_frame_cnt  <= '0;
      r_abort_pend <= 1'b0;
      r_fsmind1    <= 1'b0;
      r_fsmind0ack <= 1'b0;
      r_pixres     <= 1'b0;
      r_drain      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_fsmind0ack <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_exp_m1     <= (EXP_TIME == '0) ? '0 : EXP_TIME - 1'b1;
            r_num_frames <= (NUM_FRAMES == '0) ? C_FRM_W'(1) : NUM_FRAMES;
            r_frame_cnt  <= '0;
            r_abort_pend <= 1'b0;
            r_state      <= ST_GRST;
            r_pixres     <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ST_GRST: begin
          if (ABORT) begin
            r_state  <= ST_IDLE;
            r_pixres <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_tmr_zero) begin
            r_state  <= ST_EXPOSE;
            r_pixres <= 1'b0;
            r_drain  <= 1'b1;
          end
        end
        ST_EXPOSE: begin
          if (ABORT) begin
            r_state <= ST_IDLE;
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_tmr_zero) begin
            r_state <= ST_SETTLE;
            r_drain <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (ABORT) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_tmr_zero) begin
            r_state   <= ST_REQ;
            r_fsmind1 <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ABORT || w_timeout) begin
            r_state   <= ST_IDLE;
            r_fsmind1 <= 1'b0;
            r_busy    <= 1'b0;
          end else if (FSMIND1ACK) begin
            r_state   <= ST_READ;
            r_fsmind1 <= 1'b0;
          end
        end
        ST_READ: begin
          if (ABORT) begin
            r_abort_pend <= 1'b1;
          end
          if (w_timeout) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_abort_pend <= 1'b0;
          end else if (FSMIND0 && !FSMIND1ACK) begin
            r_state      <= ST_ACK;
            r_fsmind0ack <= 1'b1;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          if (w_ack_to_idle) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_abort_pend <= 1'b0;
          end else begin
            r_state  <= ST_GRST;
            r_pixres <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_fsmind1 <= 1'b0;
          r_pixres  <= 1'b0;
          r_drain   <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign FSMIND1    = r_fsmind1;
  assign FSMIND0ACK = r_fsmind0ack;
  assign PIXRES_G   = r_pixres;
  assign DRAIN_B    = r_drain;
  assign BUSY       = r_busy;
  assign FRAME_DONE = r_frame_done;
  assign FRAME_CNT  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exposure_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_exposure_sequencer
// Description : Self-checking bench for exposure_sequencer with a behavioural
//               readout FSM and a per-frame expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exposure_sequencer;

  localparam int c_grst   = 16;
  localparam int c_settle = 4;
  localparam int c_tmo    = 50;

  logic        ADC_PIXCLK = 1'b0;
  logic        RESET_N    = 1'b0;
  logic        START      = 1'b0;
  logic        ABORT      = 1'b0;
  logic        CONTINUOUS = 1'b0;
  logic [15:0] NUM_FRAMES = '0;
  logic [23:0] EXP_TIME   = '0;
  logic        FSMIND0    = 1'b1;
  logic        FSMIND1ACK = 1'b0;
  logic        FSMIND1, FSMIND0ACK, PIXRES_G, DRAIN_B, BUSY, FRAME_DONE, ERROR;
  logic [15:0] FRAME_CNT;

  exposure_sequencer #(
    .C_EXP_W      (24),
    .C_FRM_W      (16),
    .C_GRST_CNT   (c_grst),
    .C_SETTLE_CNT (c_settle),
    .C_TIMEOUT    (c_tmo)
  ) dut (
    .ADC_PIXCLK (ADC_PIXCLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .ABORT      (ABORT),
    .CONTINUOUS (CONTINUOUS),
    .NUM_FRAMES (NUM_FRAMES),
    .EXP_TIME   (EXP_TIME),
    .FSMIND0    (FSMIND0),
    .FSMIND1ACK (FSMIND1ACK),
    .FSMIND1    (FSMIND1),
    .FSMIND0ACK (FSMIND0ACK),
    .PIXRES_G   (PIXRES_G),
    .DRAIN_B    (DRAIN_B),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_CNT  (FRAME_CNT),
    .ERROR      (ERROR)
  );

  always #5 ADC_PIXCLK = ~ADC_PIXCLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, req, $time);
    end
  endtask

  // Expected per-frame results
  typedef struct {
    int cnt;
    int drain;
  } frame_exp_t;
  frame_exp_t exp_q[$];

  task automatic push_frames(input int n, input int exp_t);
    frame_exp_t e;
    for (int i = 1; i <= n; i++) begin
      e.cnt   = i;
      e.drain = (exp_t == 0) ? 1 : exp_t;
      exp_q.push_back(e);
    end
  endtask

  // Behavioural readout FSM
  int rd_ack_dly   = 3;
  int rd_len       = 500;
  bit rd_never_ack = 1'b0;

  initial begin
    forever begin
      @(negedge ADC_PIXCLK);
      if (FSMIND1 && !rd_never_ack) begin
        repeat (rd_ack_dly) @(posedge ADC_PIXCLK);
        #1 FSMIND1ACK = 1'b1;
        FSMIND0 = 1'b0;
        repeat (rd_len) @(posedge ADC_PIXCLK);
        #1 FSMIND1ACK = 1'b0;
        FSMIND0 = 1'b1;
      end
    end
  end

  // Output monitor: measure phase lengths, score each completed frame
  int  pix_run = 0, last_pix = 0;
  int  drn_run = 0, last_drn = 0;
  int  req_run = 0, last_req = 0;
  int  gap = 0, last_gap = 0;
  bit  gap_on = 1'b0;
  logic prev_drain = 1'b0;
  int  done_cnt = 0;
  int  excl_viol = 0;

  always @(negedge ADC_PIXCLK) begin
    frame_exp_t e;
    if (PIXRES_G) pix_run++;
    else if (pix_run != 0) begin last_pix = pix_run; pix_run = 0; end
    if (DRAIN_B) drn_run++;
    else if (drn_run != 0) begin last_drn = drn_run; drn_run = 0; end
    if (FSMIND1) req_run++;
    else if (req_run != 0) begin last_req = req_run; req_run = 0; end
    if (prev_drain && !DRAIN_B) begin gap_on = 1'b1; gap = 0; end
    if (gap_on) begin
      if (FSMIND1) begin last_gap = gap; gap_on = 1'b0; end
      else gap++;
    end
    prev_drain = DRAIN_B;
    if ((int'(PIXRES_G) + int'(DRAIN_B) + int'(FSMIND1)) > 1) excl_viol++;
    if (FRAME_DONE) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_frame_done", 32'(done_cnt), 32'(done_cnt - 1));
      end else begin
        e = exp_q.pop_front();
        check_eq("frame_cnt", 32'(FRAME_CNT), 32'(e.cnt));
        check_eq("pixres_len", 32'(last_pix), 32'(c_grst));
        check_eq("drain_len", 32'(last_drn), 32'(e.drain));
        check_eq("settle_gap", 32'(last_gap), 32'(c_settle));
        check_eq("fsmind0ack_with_done", 32'(FSMIND0ACK), 32'd1);
      end
    end
  end

  task automatic pulse_start;
    @(posedge ADC_PIXCLK); #1 START = 1'b1;
    @(posedge ADC_PIXCLK); #1 START = 1'b0;
    @(negedge ADC_PIXCLK);
  endtask

  task automatic pulse_abort;
    @(posedge ADC_PIXCLK); #1 ABORT = 1'b1;
    @(posedge ADC_PIXCLK); #1 ABORT = 1'b0;
    @(negedge ADC_PIXCLK);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && BUSY; i++) @(negedge ADC_PIXCLK);
    check_eq(tag, 32'(BUSY), 32'd0);
  endtask

  // Global time limit
  initial begin
    #800000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int d0;
    // Reset state
    repeat (3) @(posedge ADC_PIXCLK);
    @(negedge ADC_PIXCLK);
    check_eq("rst_busy", 32'(BUSY), 0);
    check_eq("rst_frame_cnt", 32'(FRAME_CNT), 0);
    check_eq("rst_outputs", {PIXRES_G, DRAIN_B, FSMIND1, FSMIND0ACK, FRAME_DONE, ERROR}, 0);
    @(posedge ADC_PIXCLK); #1 RESET_N = 1'b1;

    // Single frame, long readout
    rd_ack_dly = 3; rd_len = 500;
    EXP_TIME = 24'd100; NUM_FRAMES = 16'd1; CONTINUOUS = 1'b0;
    d0 = done_cnt;
    push_frames(1, 100);
    pulse_start;
    check_eq("t1_busy_after_start", 32'(BUSY), 1);
    check_eq("t1_pixres_after_start", 32'(PIXRES_G), 1);
    wait_idle("t1_idle", 2000);
    check_eq("t1_frame_cnt", 32'(FRAME_CNT), 1);
    check_eq("t1_done_pulses", 32'(done_cnt - d0), 1);

    // Three frames
    rd_ack_dly = 2; rd_len = 10;
    EXP_TIME = 24'd20; NUM_FRAMES = 16'd3;
    d0 = done_cnt;
    push_frames(3, 20);
    pulse_start;
    wait_idle("t2_idle", 2000);
    check_eq("t2_frame_cnt", 32'(FRAME_CNT), 3);
    check_eq("t2_done_pulses", 32'(done_cnt - d0), 3);

    // Clamping of zero exposure and zero frame count
    EXP_TIME = 24'd0; NUM_FRAMES = 16'd0;
    d0 = done_cnt;
    push_frames(1, 0);
    pulse_start;
    wait_idle("t3_idle", 1000);
    check_eq("t3_frame_cnt", 32'(FRAME_CNT), 1);
    check_eq("t3_done_pulses", 32'(done_cnt - d0), 1);

    // START and ABORT together in IDLE: stay idle
    @(posedge ADC_PIXCLK); #1 START = 1'b1; ABORT = 1'b1;
    @(posedge ADC_PIXCLK); #1 START = 1'b0; ABORT = 1'b0;
    @(negedge ADC_PIXCLK);
    check_eq("t4_start_abort_busy", 32'(BUSY), 0);

    // Continuous: five frames then abort in the next global reset
    EXP_TIME = 24'd8; NUM_FRAMES = 16'd2; CONTINUOUS = 1'b1;
    d0 = done_cnt;
    push_frames(5, 8);
    pulse_start;
    for (int i = 0; i < 5000 && (done_cnt - d0) < 5; i++) @(negedge ADC_PIXCLK);
    check_eq("t5_reached_5", 32'(done_cnt - d0), 5);
    pulse_abort;
    check_eq("t5_pixres_after_abort", 32'(PIXRES_G), 0);
    wait_idle("t5_idle", 50);
    CONTINUOUS = 1'b0;
    check_eq("t5_frame_cnt", 32'(FRAME_CNT), 5);

    // Abort mid-exposure
    EXP_TIME = 24'd50; NUM_FRAMES = 16'd1;
    d0 = done_cnt;
    pulse_start;
    for (int i = 0; i < 100 && !DRAIN_B; i++) @(negedge ADC_PIXCLK);
    check_eq("t6_drain_seen", 32'(DRAIN_B), 1);
    repeat (10) @(negedge ADC_PIXCLK);
    pulse_abort;
    check_eq("t6_drain_low", 32'(DRAIN_B), 0);
    check_eq("t6_busy", 32'(BUSY), 0);
    check_eq("t6_frame_cnt", 32'(FRAME_CNT), 0);
    check_eq("t6_done_pulses", 32'(done_cnt - d0), 0);

    // Abort mid-readout: the frame still completes and counts
    rd_ack_dly = 2; rd_len = 40;
    EXP_TIME = 24'd10; NUM_FRAMES = 16'd3;
    d0 = done_cnt;
    push_frames(1, 10);
    pulse_start;
    for (int i = 0; i < 200 && !FSMIND1ACK; i++) @(negedge ADC_PIXCLK);
    check_eq("t7_ack_seen", 32'(FSMIND1ACK), 1);
    repeat (5) @(negedge ADC_PIXCLK);
    pulse_abort;
    wait_idle("t7_idle", 200);
    check_eq("t7_frame_cnt", 32'(FRAME_CNT), 1);
    check_eq("t7_done_pulses", 32'(done_cnt - d0), 1);

    // Reset during the second frame's readout request
    rd_len = 10;
    EXP_TIME = 24'd10; NUM_FRAMES = 16'd2;
    d0 = done_cnt;
    push_frames(1, 10);
    pulse_start;
    for (int i = 0; i < 500 && (done_cnt - d0) < 1; i++) @(negedge ADC_PIXCLK);
    rd_never_ack = 1'b1;
    for (int i = 0; i < 200 && !FSMIND1; i++) @(negedge ADC_PIXCLK);
    check_eq("t8_req_seen", 32'(FSMIND1), 1);
    check_eq("t8_cnt_before_reset", 32'(FRAME_CNT), 1);
    @(posedge ADC_PIXCLK); #2 RESET_N = 1'b0;
    #1;
    check_eq("t8_rst_fsmind1", 32'(FSMIND1), 0);
    check_eq("t8_rst_busy", 32'(BUSY), 0);
    check_eq("t8_rst_frame_cnt", 32'(FRAME_CNT), 0);
    @(posedge ADC_PIXCLK); #1 RESET_N = 1'b1;
    rd_never_ack = 1'b0;
    EXP_TIME = 24'd5; NUM_FRAMES = 16'd1;
    d0 = done_cnt;
    push_frames(1, 5);
    pulse_start;
    wait_idle("t8_post_idle", 500);
    check_eq("t8_post_frame_cnt", 32'(FRAME_CNT), 1);
    check_eq("t8_post_done_pulses", 32'(done_cnt - d0), 1);

`ifdef READOUT_TIMEOUT_EN
    // Readout never acknowledges: watchdog expires
    rd_never_ack = 1'b1;
    EXP_TIME = 24'd5; NUM_FRAMES = 16'd1;
    d0 = done_cnt;
    pulse_start;
    wait_idle("t9_idle", 500);
    @(negedge ADC_PIXCLK);
    check_eq("t9_error", 32'(ERROR), 1);
    check_eq("t9_fsmind1", 32'(FSMIND1), 0);
    check_eq("t9_req_len", 32'(last_req), 32'(c_tmo));
    check_eq("t9_done_pulses", 32'(done_cnt - d0), 0);
    rd_never_ack = 1'b0;
    push_frames(1, 5);
    pulse_start;
    check_eq("t9_error_cleared", 32'(ERROR), 0);
    wait_idle("t9_post_idle", 500);
    check_eq("t9_post_frame_cnt", 32'(FRAME_CNT), 1);
`else
    check_eq("error_tied_low", 32'(ERROR), 0);
`endif

    repeat (3) @(negedge ADC_PIXCLK);
    check_eq("expect_queue_empty", 32'(exp_q.size()), 0);
    check_eq("output_exclusion", 32'(excl_viol), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
